// File: rtl/uart_tx_arbiter_if.sv
// Request, acknowledge and line-status signals shared by two byte sources and the UART transmit arbiter.
// The arbiter takes the slave modport; whoever drives the requests takes the master modport.
interface uart_tx_arbiter_if;
    logic [1:0] i_req;
    logic [1:0] i_last;
    logic [7:0] i_data0;
    logic [7:0] i_data1;
    logic [1:0] o_ack;
    logic       o_owner;
    logic       o_locked;
    logic       o_busy;
    logic       o_tx;

    modport master (
        output i_req,
        output i_last,
        output i_data0,
        output i_data1,
        input  o_ack,
        input  o_owner,
        input  o_locked,
        input  o_busy,
        input  o_tx
    );

    modport slave (
        input  i_req,
        input  i_last,
        input  i_data0,
        input  i_data1,
        output o_ack,
        output o_owner,
        output o_locked,
        output o_busy,
        output o_tx
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-source 8N1 UART transmitter with packet-granular round-robin lock and a lock timeout.
//
// state   | meaning
// S_IDLE  | line high, choose a requester, run the lock timeout
// S_START | start bit (low) for BAUD_DIV cycles
// S_DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// S_STOP  | stop bit (high); a last byte releases the lock on exit
module uart_tx_arbiter #(
    parameter int BAUD_DIV     = 868,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic               clock,
    input  logic               i_reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state_q,  state_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic          last_q,   last_d;
    logic          owner_q,  owner_d;
    logic          locked_q, locked_d;
    logic          ptr_q,    ptr_d;
    logic          tx_q,     tx_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic       grant_vld;
    logic       grant_idx;
    logic [1:0] ack;
    logic       baud_wrap;
    logic       count_en;
    logic       expire;

    // The ack is a Mealy output so the byte is captured in the very cycle it is granted.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = owner_q;
        if (state_q == S_IDLE && !i_reset) begin
            if (locked_q) begin
                grant_vld = bus.i_req[owner_q];
                grant_idx = owner_q;
            end else if (bus.i_req[ptr_q]) begin
                grant_vld = 1'b1;
                grant_idx = ptr_q;
            end else if (bus.i_req[~ptr_q]) begin
                grant_vld = 1'b1;
                grant_idx = ~ptr_q;
            end
        end
    end

    assign ack       = {grant_vld & grant_idx, grant_vld & ~grant_idx};
    assign baud_wrap = (baud_q == BAUD_LAST);

    // An owner request blocks counting, so a request on the expiry cycle wins over the timeout.
    assign count_en = (LOCK_TIMEOUT != 0) && (state_q == S_IDLE) && locked_q
                      && !bus.i_req[owner_q];
    assign expire   = count_en && (to_cnt_q == TO_MAX);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        last_d   = last_q;
        owner_d  = owner_q;
        locked_d = locked_q;
        ptr_d    = ptr_q;
        tx_d     = tx_q;
        to_cnt_d = '0;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (count_en) begin
                    to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
                end
                if (expire) begin
                    locked_d = 1'b0;
                    ptr_d    = ~owner_q;
                end
                if (grant_vld) begin
                    state_d  = S_START;
                    shift_d  = grant_idx ? bus.i_data1 : bus.i_data0;
                    last_d   = bus.i_last[grant_idx];
                    owner_d  = grant_idx;
                    locked_d = 1'b1;
                    tx_d     = 1'b0;
                    to_cnt_d = '0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                    if (last_q) begin
                        locked_d = 1'b0;
                        ptr_d    = ~owner_q;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            last_q   <= 1'b0;
            owner_q  <= 1'b0;
            locked_q <= 1'b0;
            ptr_q    <= 1'b0;
            tx_q     <= 1'b1;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            ptr_q    <= ptr_d;
            tx_q     <= tx_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign bus.o_ack    = ack;
    assign bus.o_owner  = owner_q;
    assign bus.o_locked = locked_q;
    assign bus.o_busy   = (state_q != S_IDLE);
    assign bus.o_tx     = tx_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the board's single UART transmit line (`uart_rxd_out` at the top level) between two on-chip byte sources, for example the soft-processor console and a hardware debug/loopback stream. The block contains its own 8N1 serializer. It grants the line round-robin at packet granularity: once a requester wins, it keeps the line until it sends a byte marked last. A lock timeout stops a stalled owner from starving the other requester.

## Interface
- `BAUD_DIV`, 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥2.
- `LOCK_TIMEOUT`, 100000: idle cycles the owner may hold the lock without requesting. 0 disables the timeout.
- `clock` in 1: single clock, all logic on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_req` in 2: per-requester byte request, level. Held until acked.
- `i_last` in 2: per-requester flag; the current byte ends that requester's packet.
- `i_data0` in 8: requester 0 byte. Stable while `i_req[0]` is high.
- `i_data1` in 8: requester 1 byte. Stable while `i_req[1]` is high.
- `o_ack` in 2 → out 2: one-cycle pulse; the byte and `i_last` of that requester were captured.
- `o_owner` out 1: index of the current/last granted requester.
- `o_locked` out 1: a packet is in progress and the line is reserved for `o_owner`.
- `o_busy` out 1: serializer is not in IDLE.
- `o_tx` out 1: serial output, idle high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE, selection:**
  - If `o_locked`, only `o_owner` is eligible.
  - Otherwise the eligible requester is the one matching the priority pointer if it requests, else the other one.
- **IDLE, with an eligible request:**
  - Pulse `o_ack[k]`.
  - Latch the data byte and `i_last[k]`.
  - Set `o_owner=k` and `o_locked=1`.
  - Go to START.
- **START:** `o_tx=0` for BAUD_DIV cycles, then go to DATA.
- **DATA:** 8 bits, LSB first, each held BAUD_DIV cycles. A 3-bit index counts them. Go to STOP after bit 7.
- **STOP:** `o_tx=1` for BAUD_DIV cycles, then go to IDLE.
  - If the latched last flag is 1, the same transition clears `o_locked` and sets the priority pointer to `~o_owner`.
- **Lock timeout:**
  - While in IDLE with `o_locked=1` and `i_req[o_owner]=0`, a counter increments each cycle.
  - On reaching LOCK_TIMEOUT, it clears `o_locked` and moves the pointer to `~o_owner`.
  - The counter resets on any ack or when leaving IDLE.
- A non-owner request during a locked packet waits. It receives no ack, and no error is raised.
- Simultaneous requests while unlocked: the pointer wins.
- Simultaneous timeout expiry and owner request in the same cycle: the request wins; it is acked and the lock is kept.
- `i_req`, `i_last` and data are ignored outside IDLE.
- The baud counter width is `$clog2(BAUD_DIV)` and it wraps at BAUD_DIV-1.
- The timeout counter saturates at LOCK_TIMEOUT.

## Timing
- **Reset values:** `o_tx=1`, `o_ack=0`, `o_busy=0`, `o_owner=0`, `o_locked=0`, pointer=0, state IDLE.
- **Reset mid-frame:** `o_tx` returns high immediately (asynchronously). The partial frame is abandoned and the lock is dropped.
- **Ack cycle T:** IDLE with an eligible request. `o_ack` is high during T only.
- **Frame layout after ack at T:**
  - Start bit drives `o_tx` low for cycles T+1 … T+BAUD_DIV.
  - Data bit i occupies cycles T+1+(i+1)·BAUD_DIV … T+(i+2)·BAUD_DIV.
  - Stop bit occupies cycles T+1+9·BAUD_DIV … T+10·BAUD_DIV.
- IDLE is re-entered at T+10·BAUD_DIV+1; the earliest next ack is in that cycle.
- Minimum frame period: 10·BAUD_DIV+1 cycles.
- `o_busy` is high from T+1 through T+10·BAUD_DIV.
- Lock release from a last byte is visible in the first IDLE cycle, so the other requester can be acked in that same cycle.

## Test plan
Run all scenarios with BAUD_DIV=4 and LOCK_TIMEOUT=20.
- **Reset/idle:** assert `i_reset` mid-stream → `o_tx=1`, `o_busy=0`, `o_locked=0`, `o_ack=00` within the same cycle.
- **Single byte:** `i_req=01`, `i_data0=0xA5`, `i_last=01` →
  - `o_ack=01` for one cycle;
  - `o_tx` shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each 4 cycles;
  - `o_locked` returns to 0 at cycle T+41.
- **Packet lock:** requester 0 sends 0x11 (last=0) and then 0x22 (last=1), while `i_req[1]` is held high with 0x33 →
  - order on the line is 0x11, 0x22, 0x33;
  - no `o_ack[1]` occurs before 0x22's stop completes.
- **Round-robin fairness:** both requesters continuously request single-byte packets (`i_last=11`) → acks alternate 0,1,0,1, with ack spacing exactly 41 cycles.
- **Lock timeout:** requester 0 sends 0x55 with last=0, then drops `i_req`; requester 1 is requesting →
  - `o_locked` clears 20 cycles after re-entering IDLE;
  - `o_ack[1]` follows in the next cycle.
- **Timeout vs request tie:** requester 0 re-asserts `i_req` exactly on the expiry cycle → `o_ack[0]` is given, `o_locked` stays 1, and requester 1 is not acked.
